uart_tx: RTL and testbench

UART transmit serializer. Sits directly downstream of the baud rate generator and consumes its 1x `tick`.
- Accepts one parallel byte per valid/ready handshake.
- Drives the serial line: start bit, data LSB-first, optional parity, stop bit(s).
- Drives the generator's `enable`, so the bit timing restarts cleanly for every frame.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_if.sv | 25 ++
 rtl/uart_tx.sv | 170 +++++++++++++++++
 tb/tb_uart_tx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the TX block (and the future RX block).
//   tx_state_e      : serializer state encoding, exposed on uart_tx.state_dbg
//   UART_*_LEVEL    : serial line levels for idle/stop and start
//   MIN/MAX_DATA_BITS : legal range of the DATA_BITS parameter
//   calc_parity()   : even/odd parity over a zero-extended data word
// The package itself has no configuration macros. UART_TX_PARITY_EN is
// consumed only by uart_tx.sv.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;

  // Callers zero-extend narrower words. Zero bits do not change the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Parallel byte handshake into the UART transmitter.
//   tx_data  : byte to send. It is sampled only on the handshake cycle.
//   tx_valid : upstream has a byte.
//   tx_ready : transmitter can accept a byte. It is high only in IDLE.
// Handshake: a transfer happens on every rising clk edge where
// tx_valid && tx_ready. The transmitter does not buffer anything. While
// tx_ready is low, it ignores tx_valid and tx_data. A master that holds
// tx_valid high across a frame gets its next transfer on the first IDLE
// cycle after the frame ends.
// Modports: master (upstream source), slave (uart_tx).
// -----------------------------------------------------------------------------
interface uart_tx_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmit serializer. It is driven by a 1x bit tick from an external
// baud generator. It sends the start bit, then DATA_BITS data bits LSB
// first, then an optional parity bit, then STOP_BITS stop bits. baud_en
// drives the generator's enable, so each frame's bit timing starts from a
// cleared generator counter.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : a parity bit with sense PARITY_ODD follows the data bits.
//   undefined : the PARITY state and the parity register are not built.
//
// Parameters: DATA_BITS (5..9), STOP_BITS (1 or 2),
//             PARITY_ODD (0 = even, 1 = odd).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : one-cycle pulse per bit period from the baud generator
//   bus        : uart_tx_if.slave (tx_data, tx_valid, tx_ready)
//   baud_en    : baud generator enable (registered)
//   tx         : serial line, idle high (registered)
//   busy       : frame in progress (registered)
//   tx_done    : one-cycle pulse as the frame ends (registered)
//   state_dbg  : current FSM state
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  uart_tx_if.slave      bus,
  output logic          baud_en,
  output logic          tx,
  output logic          busy,
  output logic          tx_done,
  output tx_state_e     state_dbg
);

  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS ||
      !(STOP_BITS == 1 || STOP_BITS == 2) ||
      !(PARITY_ODD == 0 || PARITY_ODD == 1)) begin : g_bad_param
    $error("uart_tx: illegal parameter combination");
  end

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [3:0]           bit_cnt_q;
  logic                 stop_cnt_q;

`ifdef UART_TX_PARITY_EN
  logic                     parity_q;
  logic [MAX_DATA_BITS-1:0] par_in;

  always_comb begin
    par_in                = '0;
    par_in[DATA_BITS-1:0] = bus.tx_data;
  end
`endif

  // tx_ready comes straight from the state register. Every other output
  // is registered.
  assign bus.tx_ready = (state_q == IDLE);
  assign state_dbg    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx         <= UART_IDLE_LEVEL;
      baud_en    <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state_q)
        // tick is ignored here. The generator is disabled in IDLE, so a
        // tick on the handshake cycle cannot shorten the start bit.
        IDLE: begin
          tx      <= UART_IDLE_LEVEL;
          baud_en <= 1'b0;
          busy    <= 1'b0;
          if (bus.tx_valid) begin
            shift_q    <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
            parity_q   <= calc_parity(par_in, PARITY_ODD != 0);
`endif
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            state_q    <= START;
            tx         <= UART_START_LEVEL;
            baud_en    <= 1'b1;
            busy       <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            state_q <= DATA;
            tx      <= shift_q[0];
          end
        end

        // On each tick, the bit that is next on the line is bit 1 of the
        // register before it shifts.
        DATA: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= PARITY;
              tx        <= parity_q;
`else
              state_q   <= STOP;
              tx        <= UART_IDLE_LEVEL;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              tx        <= shift_q[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            tx      <= UART_IDLE_LEVEL;
          end
        end
`endif

        STOP: begin
          tx <= UART_IDLE_LEVEL;
          if (tick) begin
            if (stop_cnt_q == LAST_STOP) begin
              stop_cnt_q <= 1'b0;
              state_q    <= IDLE;
              baud_en    <= 1'b0;
              busy       <= 1'b0;
              tx_done    <= 1'b1;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          tx      <= UART_IDLE_LEVEL;
          baud_en <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Bench for uart_tx. The baud model divides by 10, which stands in for a
// 1 MHz clock with a 100 kbaud generator. The counter clears while enable
// is low.
//   dut1 : STOP_BITS=1, PARITY_ODD=0
//   dut2 : STOP_BITS=2, PARITY_ODD=1
// The parity bit appears in the frame only when UART_TX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CLK_PER_BIT = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int N1 = 1 + 8 + P + 1;
  localparam int N2 = 1 + 8 + P + 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs + baud models ----------------
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();

  logic tick1, tick2, be1, be2, tx1, tx2, busy1, busy2, done1, done2;
  tx_state_e st1, st2;
  int unsigned cnt1, cnt2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt1 <= 0;
    else if (!be1)                     cnt1 <= 0;
    else if (cnt1 == CLK_PER_BIT - 1)  cnt1 <= 0;
    else                               cnt1 <= cnt1 + 1;
  end
  assign tick1 = be1 && (cnt1 == CLK_PER_BIT - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt2 <= 0;
    else if (!be2)                     cnt2 <= 0;
    else if (cnt2 == CLK_PER_BIT - 1)  cnt2 <= 0;
    else                               cnt2 <= cnt2 + 1;
  end
  assign tick2 = be2 && (cnt2 == CLK_PER_BIT - 1);

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick1), .bus(if1.slave),
    .baud_en(be1), .tx(tx1), .busy(busy1), .tx_done(done1), .state_dbg(st1)
  );

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick2), .bus(if2.slave),
    .baud_en(be2), .tx(tx2), .busy(busy2), .tx_done(done2), .state_dbg(st2)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [11:0] exp_q1[$];
  logic [11:0] exp_q2[$];
  int frames_done[1:2];
  int gap_len[1:2], gap_be_low[1:2], gap_tx_high[1:2];
  int last_gap[1:2], last_be_low[1:2], last_tx_high[1:2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {tx, busy, baud_en, tx_done, tx_ready}
  function automatic logic [4:0] sig(input int s);
    if (s == 1) return {tx1, busy1, be1, done1, if1.tx_ready};
    else        return {tx2, busy2, be2, done2, if2.tx_ready};
  endfunction

  // Expected frame bits: bit 0 is the start bit. The parity argument is
  // the hand-computed even parity of d.
  function automatic logic [11:0] exp_word(input int s, input logic [7:0] d, input logic pe);
    logic [11:0] w;
    w      = '1;
    w[0]   = 1'b0;
    w[8:1] = d;
`ifdef UART_TX_PARITY_EN
    w[9]   = (s == 2) ? ~pe : pe;
`endif
    return w;
  endfunction

  // ---------------- monitor ----------------
  task automatic monitor(input int s);
    logic         prev = 1'b1;
    logic [4:0]   v;
    logic [159:0] samp;
    logic [11:0]  word;
    logic [11:0]  exp;
    logic         ok_bits, ok_ctrl, aborted, have_exp;
    int           n;
    n = (s == 1) ? N1 : N2;
    forever begin
      @(negedge clk);
      v = sig(s);
      if (rst_n && prev === 1'b1 && v[4] === 1'b0) begin
        last_gap[s]     = gap_len[s];
        last_be_low[s]  = gap_be_low[s];
        last_tx_high[s] = gap_tx_high[s];
        ok_ctrl = 1'b1;
        aborted = 1'b0;
        samp    = '1;
        for (int k = 0; k < n * CLK_PER_BIT; k++) begin
          if (k > 0) begin
            @(negedge clk);
            v = sig(s);
          end
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          samp[k] = v[4];
          if (v[3] !== 1'b1 || v[2] !== 1'b1 || v[1] !== 1'b0 || v[0] !== 1'b0) ok_ctrl = 1'b0;
        end
        if (!aborted) begin
          @(negedge clk);
          v = sig(s);
          if (!rst_n) aborted = 1'b1;
        end
        if (aborted) begin
          prev = 1'b1;
          gap_len[s] = 0; gap_be_low[s] = 0; gap_tx_high[s] = 0;
          continue;
        end
        word    = '1;
        ok_bits = 1'b1;
        for (int b = 0; b < n; b++) begin
          word[b] = samp[b*CLK_PER_BIT];
          for (int j = 1; j < CLK_PER_BIT; j++)
            if (samp[b*CLK_PER_BIT+j] !== samp[b*CLK_PER_BIT]) ok_bits = 1'b0;
        end
        check($sformatf("bit_hold_dut%0d", s), 32'(ok_bits), 32'd1);
        check($sformatf("frame_ctrl_dut%0d", s), 32'(ok_ctrl), 32'd1);
        check($sformatf("frame_end_dut%0d", s), 32'(v), 32'b10011);
        have_exp = (s == 1) ? (exp_q1.size() > 0) : (exp_q2.size() > 0);
        if (!have_exp) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_frame_dut%0d: got %0h want none", s, word);
        end else begin
          exp = (s == 1) ? exp_q1.pop_front() : exp_q2.pop_front();
          check($sformatf("frame_bits_dut%0d", s), 32'(word), 32'(exp));
        end
        frames_done[s]++;
        gap_len[s]     = 1;
        gap_be_low[s]  = (v[2] === 1'b0) ? 1 : 0;
        gap_tx_high[s] = (v[4] === 1'b1) ? 1 : 0;
        prev = v[4];
      end else begin
        if (v[0] === 1'b1) begin
          gap_len[s]++;
          if (v[2] === 1'b0) gap_be_low[s]++;
          if (v[4] === 1'b1) gap_tx_high[s]++;
        end
        prev = v[4];
      end
    end
  endtask

  initial monitor(1);
  initial monitor(2);

  // ---------------- driver tasks ----------------
  task automatic drive(input int s, input logic [7:0] d, input logic v);
    if (s == 1) begin if1.tx_data = d; if1.tx_valid = v; end
    else        begin if2.tx_data = d; if2.tx_valid = v; end
  endtask

  task automatic send(input int s, input logic [7:0] d, input logic push,
                      input logic pe, input logic hold);
    int t;
    t = 0;
    @(negedge clk);
    while (!sig(s)[0] && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      check($sformatf("ready_timeout_dut%0d", s), 32'd0, 32'd1);
      drive(s, d, 1'b0);
      return;
    end
    drive(s, d, 1'b1);
    if (push) begin
      if (s == 1) exp_q1.push_back(exp_word(s, d, pe));
      else        exp_q2.push_back(exp_word(s, d, pe));
    end
    @(posedge clk);
    #1;
    if (!hold) drive(s, d, 1'b0);
  endtask

  task automatic wait_frames(input int s, input int target);
    int t;
    t = 0;
    while (frames_done[s] < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("frame_wait_dut%0d", s), 32'(frames_done[s] >= target), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1, 8'h00, 1'b0);
    drive(2, 8'h00, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      frames_done[i] = 0; gap_len[i] = 0; gap_be_low[i] = 0; gap_tx_high[i] = 0;
    end
    #12;
    check("reset_dut1", 32'(sig(1)), 32'b10001);
    check("reset_dut2", 32'(sig(2)), 32'b10001);
    check("reset_state_dut1", 32'(st1), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-frame. No expected entry is pushed because the frame is cut.
    send(1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("start_state_dut1", 32'(st1), 32'(START));
    repeat (35) @(negedge clk);
    check("in_data_dut1", 32'(st1), 32'(DATA));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_dut1", 32'(sig(1)), 32'b10001);
    check("async_reset_state", 32'(st1), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 0xA5 (even parity 0) on one stop bit. This also covers the first
    // frame after the reset.
    send(1, 8'hA5, 1'b1, 1'b0, 1'b0);
    wait_frames(1, 1);

    // Two stop bits with odd parity: 0x3C (even parity 0), then 0xA5 (even parity 0).
    send(2, 8'h3C, 1'b1, 1'b0, 1'b0);
    wait_frames(2, 1);
    send(2, 8'hA5, 1'b1, 1'b0, 1'b0);
    wait_frames(2, 2);

    // Back-to-back frames with tx_valid held high: 0x01 (even parity 1),
    // then 0xFF (even parity 0).
    send(1, 8'h01, 1'b1, 1'b1, 1'b1);
    send(1, 8'hFF, 1'b1, 1'b0, 1'b0);
    wait_frames(1, 3);
    check("b2b_gap_len", 32'(last_gap[1]), 32'd1);
    check("b2b_gap_be_low", 32'(last_be_low[1]), 32'd1);
    check("b2b_gap_tx_high", 32'(last_tx_high[1]), 32'd1);

    // Pulses on tx_valid and changes to tx_data while busy are ignored.
    // 0x5A has even parity 0.
    send(1, 8'h5A, 1'b1, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    drive(1, 8'hC3, 1'b1);
    check("ready_busy_a", 32'(if1.tx_ready), 32'd0);
    @(negedge clk);
    drive(1, 8'h0F, 1'b1);
    check("ready_busy_b", 32'(if1.tx_ready), 32'd0);
    @(negedge clk);
    drive(1, 8'h0F, 1'b0);
    wait_frames(1, 4);
    repeat (20) @(negedge clk);
    check("no_extra_frames_dut1", 32'(frames_done[1]), 32'd4);
    check("exp_q1_empty", 32'(exp_q1.size()), 32'd0);
    check("exp_q2_empty", 32'(exp_q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
